rf_wb_arbiter: RTL and testbench

//  Owns the single register-file write port in the pipeline CPU. Merges two writeback sources:
//  in-order pipeline WB (fixed priority) and a multi-cycle unit (MDU) whose results queue in a

---
 rtl/rf_wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: owns the single register-file write port.
// Merges in-order pipeline writeback (fixed priority) with multi-cycle unit (MDU)
// results, which queue in a small FIFO and drain only when the pipeline leaves the
// port free. A busy scoreboard tracks outstanding MDU destinations and stalls
// decode on RAW/WAW hazards.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   wb_we/wb_rd/wb_data        pipeline writeback request (always accepted)
//   mdu_issue/mdu_issue_rd     MDU op issued; marks its destination busy
//   mdu_valid/mdu_ready        MDU result handshake
//   mdu_rd/mdu_data            MDU result payload
//   dec_rs1/dec_rs2            decode-stage sources
//   dec_we/dec_rd              decode-stage destination
//   busy_stall                 hold decode this cycle
//   rf_we/rf_wa/rf_wd          register-file write port (same-cycle)
//   fifo_count                 MDU results currently queued
module rf_wb_arbiter #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned DW         = 32,
    parameter int unsigned AW         = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wb_we,
    input  logic [AW-1:0]                    wb_rd,
    input  logic [DW-1:0]                    wb_data,
    input  logic                             mdu_issue,
    input  logic [AW-1:0]                    mdu_issue_rd,
    input  logic                             mdu_valid,
    output logic                             mdu_ready,
    input  logic [AW-1:0]                    mdu_rd,
    input  logic [DW-1:0]                    mdu_data,
    input  logic [AW-1:0]                    dec_rs1,
    input  logic [AW-1:0]                    dec_rs2,
    input  logic                             dec_we,
    input  logic [AW-1:0]                    dec_rd,
    output logic                             busy_stall,
    output logic                             rf_we,
    output logic [AW-1:0]                    rf_wa,
    output logic [DW-1:0]                    rf_wd,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count
);

    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = PW + 1;
    localparam int unsigned NREG = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } mdu_entry_t;

    mdu_entry_t        mem [FIFO_DEPTH];
    mdu_entry_t        head;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              wb_eff;
    logic              push;
    logic              pop;

    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_set;
    logic [NREG-1:0]   busy_clr;
    logic [NREG-1:0]   busy_nxt;

    assign head   = mem[rd_ptr];
    assign full   = (count == CW'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign wb_eff = wb_we && (wb_rd != '0);

    // Ready depends only on stored state (and reset), never on mdu_valid.
    assign mdu_ready = !rst && !full;

    // Zero-destination results are acknowledged but never occupy a slot.
    assign push = mdu_valid && mdu_ready && (mdu_rd != '0);
    assign pop  = !rst && !wb_eff && !empty;

    assign fifo_count = count;

    // Write-port mux: pipeline WB first, otherwise drain the FIFO head.
    always_comb begin
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        if (!rst) begin
            if (wb_eff) begin
                rf_we = 1'b1;
                rf_wa = wb_rd;
                rf_wd = wb_data;
            end else if (!empty) begin
                rf_we = 1'b1;
                rf_wa = head.rd;
                rf_wd = head.data;
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally for power-of-2 depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{rd: mdu_rd, data: mdu_data};
        end
    end

    // Scoreboard update: a new issue to the same register overrides a drain clear.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (mdu_issue && (mdu_issue_rd != '0)) busy_set[mdu_issue_rd] = 1'b1;
        if (pop)                               busy_clr[head.rd]      = 1'b1;
        busy_nxt    = (busy & ~busy_clr) | busy_set;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

    // Stall is decoded from registered busy bits, so it holds through the drain cycle.
    always_comb begin
        busy_stall = ((dec_rs1 != '0) && busy[dec_rs1])
                  || ((dec_rs2 != '0) && busy[dec_rs2])
                  || (dec_we && (dec_rd != '0) && busy[dec_rd]);
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios followed by random
// traffic, all checked against a queue/array reference model.
module tb_rf_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int DW    = 32;
    localparam int AW    = 5;

    logic          clk;
    logic          rst;
    logic          wb_we;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          mdu_issue;
    logic [AW-1:0] mdu_issue_rd;
    logic          mdu_valid;
    logic          mdu_ready;
    logic [AW-1:0] mdu_rd;
    logic [DW-1:0] mdu_data;
    logic [AW-1:0] dec_rs1;
    logic [AW-1:0] dec_rs2;
    logic          dec_we;
    logic [AW-1:0] dec_rd;
    logic          busy_stall;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic [1:0]    fifo_count;

    rf_wb_arbiter #(.FIFO_DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
        .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_we(dec_we), .dec_rd(dec_rd),
        .busy_stall(busy_stall),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    int   checks   = 0;
    int   failures = 0;
    ent_t q[$];
    bit   busy_m[32];
    bit   accepted;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wb_we = 0; wb_rd = 0; wb_data = 0;
        mdu_issue = 0; mdu_issue_rd = 0;
        mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
        dec_rs1 = 0; dec_rs2 = 0; dec_we = 0; dec_rd = 0;
    endtask

    function automatic bit model_stall();
        return (dec_rs1 != 0 && busy_m[dec_rs1]) || (dec_rs2 != 0 && busy_m[dec_rs2])
            || (dec_we && dec_rd != 0 && busy_m[dec_rd]);
    endfunction

    // Called at posedge+1 with inputs already driven; checks just before the next edge.
    task automatic step();
        bit          wb_eff;
        bit          ewe;
        logic [4:0]  ewa;
        logic [31:0] ewd;
        bit          rdy;
        bit          pop;
        #3;
        wb_eff = wb_we && (wb_rd != 0);
        rdy    = (q.size() < DEPTH);
        if (wb_eff) begin
            ewe = 1; ewa = wb_rd; ewd = wb_data;
        end else if (q.size() > 0) begin
            ewe = 1; ewa = q[0].rd; ewd = q[0].data;
        end else begin
            ewe = 0; ewa = 0; ewd = 0;
        end
        chk("rf_we", 32'(rf_we), 32'(ewe));
        chk("rf_wa", 32'(rf_wa), 32'(ewa));
        chk("rf_wd", rf_wd, ewd);
        chk("mdu_ready", 32'(mdu_ready), 32'(rdy));
        chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        chk("busy_stall", 32'(busy_stall), 32'(model_stall()));
        accepted = mdu_valid && rdy;
        pop      = !wb_eff && (q.size() > 0);
        if (pop) begin
            busy_m[q[0].rd] = 0;
            void'(q.pop_front());
        end
        if (accepted && mdu_rd != 0) q.push_back('{rd: mdu_rd, data: mdu_data});
        if (mdu_issue && mdu_issue_rd != 0) busy_m[mdu_issue_rd] = 1;
        @(posedge clk);
        #1;
    endtask

    // Reset asserted and released away from clock edges; outputs must clear at once.
    task automatic reset_pulse();
        #1 rst = 1;
        #1;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_mdu_ready", 32'(mdu_ready), 32'd0);
        chk("rst_busy_stall", 32'(busy_stall), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_rf_we", 32'(rf_we), 32'd0);
        #3 rst = 0;
        q.delete();
        foreach (busy_m[i]) busy_m[i] = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned r;
        bit          vld_hold;
        logic [4:0]  pend[$];

        idle();
        rst = 1;
        foreach (busy_m[i]) busy_m[i] = 0;
        #6;
        chk("init_rf_we", 32'(rf_we), 32'd0);
        chk("init_mdu_ready", 32'(mdu_ready), 32'd0);
        chk("init_fifo_count", 32'(fifo_count), 32'd0);
        #3 rst = 0;
        @(posedge clk);
        #1;
        step();

        // Pipeline WB keeps priority while an MDU result waits.
        idle(); mdu_issue = 1; mdu_issue_rd = 5; step();
        idle(); mdu_valid = 1; mdu_rd = 5; mdu_data = 32'hAA;
        wb_we = 1; wb_rd = 3; wb_data = 32'h11; dec_rs1 = 5; step();
        mdu_valid = 0; repeat (3) step();
        wb_we = 0; step();
        step();

        // RAW stall holds through the drain cycle and drops after it.
        idle(); mdu_issue = 1; mdu_issue_rd = 7; dec_rs1 = 7; step();
        mdu_issue = 0; step();
        mdu_valid = 1; mdu_rd = 7; mdu_data = 32'h77; wb_we = 1; wb_rd = 1; wb_data = 32'h1; step();
        mdu_valid = 0; step();
        wb_we = 0; step();
        step();

        // Full FIFO back-pressures the MDU; drains in order.
        idle(); wb_we = 1; wb_rd = 2; wb_data = 32'h22;
        mdu_issue = 1; mdu_issue_rd = 10; step();
        mdu_issue_rd = 11; step();
        mdu_issue_rd = 12; step();
        mdu_issue = 0;
        mdu_valid = 1; mdu_rd = 10; mdu_data = 32'hA0; step();
        mdu_rd = 11; mdu_data = 32'hB0; step();
        mdu_rd = 12; mdu_data = 32'hC0; step(); step();
        wb_we = 0; step();
        step();
        mdu_valid = 0; step(); step();

        // Register x0 is never tracked, queued or written.
        idle(); mdu_issue = 1; mdu_issue_rd = 4; step();
        idle(); mdu_valid = 1; mdu_rd = 4; mdu_data = 32'h44; wb_we = 1; wb_rd = 6; step();
        idle(); wb_we = 1; wb_rd = 0; wb_data = 32'hDEAD;
        mdu_issue = 1; mdu_issue_rd = 0; mdu_valid = 1; mdu_rd = 0; mdu_data = 32'h55;
        dec_we = 1; dec_rd = 0; step();
        mdu_issue = 0; mdu_valid = 0; step();
        step();

        // Issue to a register whose result drains in the same cycle keeps it busy.
        idle(); mdu_issue = 1; mdu_issue_rd = 9; step();
        idle(); mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h99; wb_we = 1; wb_rd = 8; step();
        idle(); mdu_issue = 1; mdu_issue_rd = 9; step();
        idle(); dec_rs2 = 9; step();
        mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h98; step();
        idle(); step(); step();

        // Reset in the middle of queued work discards everything.
        idle(); mdu_issue = 1; mdu_issue_rd = 13; step();
        idle(); mdu_valid = 1; mdu_rd = 13; mdu_data = 32'hD0; wb_we = 1; wb_rd = 14; step();
        mdu_valid = 0; dec_rs1 = 13; step();
        reset_pulse();
        idle(); dec_rs1 = 13; step();
        step();

        // Random traffic honouring the decode no-issue-to-busy rule.
        idle();
        vld_hold = 0;
        for (int n = 0; n < 500; n++) begin
            wb_we   = ($urandom_range(0, 99) < 45);
            wb_rd   = 5'($urandom);
            wb_data = $urandom;
            if (!vld_hold && pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                vld_hold = 1;
                mdu_rd   = pend.pop_front();
                mdu_data = $urandom;
            end else if (!vld_hold && $urandom_range(0, 15) == 0) begin
                vld_hold = 1;
                mdu_rd   = 0;
                mdu_data = $urandom;
            end
            mdu_valid = vld_hold;
            mdu_issue = 0;
            if ($urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 31);
                if (r == 0 || !busy_m[r]) begin
                    mdu_issue    = 1;
                    mdu_issue_rd = 5'(r);
                    if (r != 0) pend.push_back(5'(r));
                end
            end
            dec_rs1 = 5'($urandom);
            dec_rs2 = 5'($urandom);
            dec_we  = 1'($urandom);
            dec_rd  = 5'($urandom);
            step();
            if (accepted) vld_hold = 0;
        end

        idle();
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
